// File: rtl/dmem_bridge_pkg.sv
// rtl/dmem_bridge_pkg.sv - shared constants and types for the data memory bridge
package dmem_bridge_pkg;

  localparam logic [31:0] MMIO_BASE   = 32'h8000_0000;
  localparam logic [31:0] OFF_TXDATA  = 32'h0000_0000;
  localparam logic [31:0] OFF_STATUS  = 32'h0000_0004;
  localparam logic [31:0] OFF_SCRATCH = 32'h0000_0008;

  localparam int ST_EMPTY = 0;
  localparam int ST_FULL  = 1;
  localparam int ST_OVF   = 2;
  localparam int ST_BUSY  = 3;
  localparam int ST_COUNT = 8;

  typedef enum logic [1:0] {
    TX_IDLE,
    TX_START,
    TX_DATA,
    TX_STOP
  } tx_state_e;

  // Lanes pushed past bit 3 fall off; misaligned stores are not trapped.
  function automatic logic [3:0] align_lanes(input logic [3:0] lanes, input logic [1:0] off);
    return lanes << off;
  endfunction

endpackage

// File: rtl/dmem_bridge_uart_tx.sv
// rtl/dmem_bridge_uart_tx.sv - byte FIFO feeding an 8N1 serializer
module uart_tx
  import dmem_bridge_pkg::*;
#(
  parameter int FIFO_LOG = 4,
  parameter int BAUD_DIV = 868
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              push,
  input  logic [7:0]        data,
  output logic              full,
  output logic [FIFO_LOG:0] count,
  output logic              busy,
  output logic              txd
);
  localparam int DEPTH = 1 << FIFO_LOG;
  localparam int BW = $clog2(BAUD_DIV);
  localparam logic [BW-1:0]       BAUD_LAST = BW'(BAUD_DIV - 1);
  localparam logic [BW-1:0]       BAUD_ONE  = BW'(1);
  localparam logic [FIFO_LOG-1:0] PTR_ONE   = FIFO_LOG'(1);
  localparam logic [FIFO_LOG:0]   CNT_ONE   = (FIFO_LOG + 1)'(1);

  logic [7:0]          fifo [0:DEPTH-1];
  logic [FIFO_LOG-1:0] wr_ptr, rd_ptr;
  tx_state_e           state;
  logic [BW-1:0]       baud;
  logic [2:0]          bit_idx;
  logic [7:0]          shreg;
  logic                pop, accept, baud_end;

  assign full     = (count == (FIFO_LOG + 1)'(DEPTH));
  assign busy     = (state != TX_IDLE);
  assign pop      = !busy && (count != '0);
  // A pop in the same cycle frees a slot, so a push into a full FIFO still lands.
  assign accept   = push && (!full || pop);
  assign baud_end = (baud == BAUD_LAST);

  always_ff @(posedge clk) begin
    if (accept) fifo[wr_ptr] <= data;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count   <= '0;
      state   <= TX_IDLE;
      baud    <= '0;
      bit_idx <= '0;
      shreg   <= '0;
      txd     <= 1'b1;
    end else begin
      if (accept) wr_ptr <= wr_ptr + PTR_ONE;
      if (pop) rd_ptr <= rd_ptr + PTR_ONE;
      case ({accept, pop})
        2'b10:   count <= count + CNT_ONE;
        2'b01:   count <= count - CNT_ONE;
        default: count <= count;
      endcase

      case (state)
        TX_IDLE: begin
          txd <= 1'b1;
          if (pop) begin
            shreg <= fifo[rd_ptr];
            baud  <= '0;
            txd   <= 1'b0;
            state <= TX_START;
          end
        end
        TX_START: begin
          if (baud_end) begin
            baud    <= '0;
            bit_idx <= '0;
            txd     <= shreg[0];
            state   <= TX_DATA;
          end else begin
            baud <= baud + BAUD_ONE;
          end
        end
        TX_DATA: begin
          if (baud_end) begin
            baud <= '0;
            if (bit_idx == 3'd7) begin
              txd   <= 1'b1;
              state <= TX_STOP;
            end else begin
              bit_idx <= bit_idx + 3'd1;
              shreg   <= shreg >> 1;
              txd     <= shreg[1];
            end
          end else begin
            baud <= baud + BAUD_ONE;
          end
        end
        TX_STOP: begin
          if (baud_end) begin
            baud  <= '0;
            state <= TX_IDLE;
          end else begin
            baud <= baud + BAUD_ONE;
          end
        end
        default: state <= TX_IDLE;
      endcase
    end
  end

endmodule

// File: rtl/dmem_bridge.sv
// rtl/dmem_bridge.sv - core data port to word RAM and MMIO (UART TX, scratch)
module dmem_bridge
  import dmem_bridge_pkg::*;
#(
  parameter int RAM_SCALE = 14,
  parameter int FIFO_LOG  = 4,
  parameter int BAUD_DIV  = 868
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] mem_addr,
  input  logic [3:0]  mem_oe,
  input  logic [3:0]  mem_we,
  input  logic [31:0] mem_wdata,
  output logic [31:0] mem_rdata,
  output logic        mem_valid,
  output logic        mem_ready,
  output logic        uart_txd
);
  localparam int DEPTH = 1 << FIFO_LOG;
  localparam logic [FIFO_LOG:0] CNT_ONE = (FIFO_LOG + 1)'(1);

  logic [1:0]           off;
  logic                 is_store, is_load, is_mmio;
  logic [3:0]           wlanes;
  logic [31:0]          wdata_al;
  logic [RAM_SCALE-1:0] widx;
  logic                 sel_tx, sel_status, sel_scratch;

  assign off         = mem_addr[1:0];
  assign is_store    = (|mem_oe) && (|mem_we);
  assign is_load     = (|mem_oe) && !(|mem_we);
  assign is_mmio     = (mem_addr[31] == MMIO_BASE[31]);
  assign wlanes      = align_lanes(mem_we, off);
  assign wdata_al    = mem_wdata << {off, 3'b000};
  assign widx        = mem_addr[RAM_SCALE+1:2];
  assign sel_tx      = (mem_addr[30:2] == OFF_TXDATA[30:2]);
  assign sel_status  = (mem_addr[30:2] == OFF_STATUS[30:2]);
  assign sel_scratch = (mem_addr[30:2] == OFF_SCRATCH[30:2]);

  logic              tx_push, tx_full, tx_busy, tx_pop, tx_drop;
  logic [FIFO_LOG:0] tx_count, count_next;

  assign tx_push = is_store && is_mmio && sel_tx && wlanes[0];

  uart_tx #(
    .FIFO_LOG(FIFO_LOG),
    .BAUD_DIV(BAUD_DIV)
  ) u_uart_tx (
    .clk  (clk),
    .rst  (rst),
    .push (tx_push),
    .data (wdata_al[7:0]),
    .full (tx_full),
    .count(tx_count),
    .busy (tx_busy),
    .txd  (uart_txd)
  );

  // The serializer pops whenever it is idle with data queued.
  assign tx_pop  = !tx_busy && (tx_count != '0);
  assign tx_drop = tx_push && tx_full && !tx_pop;

  always_comb begin
    count_next = tx_count;
    if (tx_push && !tx_drop) count_next = count_next + CNT_ONE;
    if (tx_pop) count_next = count_next - CNT_ONE;
  end

  assign mem_ready = !rst && (int'(count_next) <= DEPTH - 2);

  logic [31:0] status_word, mmio_rd, scratch, mmio_q, ram_q;
  logic        overflow, from_ram;
  logic [3:0]  oe_q;
  logic [1:0]  off_q;

  always_comb begin
    status_word = '0;
    status_word[ST_EMPTY] = (tx_count == '0);
    status_word[ST_FULL]  = tx_full;
    status_word[ST_OVF]   = overflow;
    status_word[ST_BUSY]  = tx_busy;
    status_word[ST_COUNT +: FIFO_LOG+1] = tx_count;
  end

  always_comb begin
    mmio_rd = '0;
    if (sel_status) mmio_rd = status_word;
    else if (sel_scratch) mmio_rd = scratch;
  end

  logic [31:0] ram [0:(1<<RAM_SCALE)-1];

  always_ff @(posedge clk) begin
    for (int i = 0; i < 4; i++) begin
      if (is_store && !is_mmio && wlanes[i]) ram[widx][8*i +: 8] <= wdata_al[8*i +: 8];
    end
    if (is_load && !is_mmio) ram_q <= ram[widx];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      mem_valid <= 1'b0;
      oe_q      <= '0;
      off_q     <= '0;
      from_ram  <= 1'b0;
      mmio_q    <= '0;
      overflow  <= 1'b0;
      scratch   <= '0;
    end else begin
      mem_valid <= is_load;
      if (is_load) begin
        oe_q     <= mem_oe;
        off_q    <= off;
        from_ram <= !is_mmio;
        if (is_mmio) mmio_q <= mmio_rd;
      end
      if (tx_drop) overflow <= 1'b1;
      else if (is_load && is_mmio && sel_status) overflow <= 1'b0;
      for (int i = 0; i < 4; i++) begin
        if (is_store && is_mmio && sel_scratch && wlanes[i]) scratch[8*i +: 8] <= wdata_al[8*i +: 8];
      end
    end
  end

  // Load data is realigned after the register so the RAM read stays a plain word read.
  logic [31:0] rd_word, rd_shift;

  always_comb begin
    rd_word   = from_ram ? ram_q : mmio_q;
    rd_shift  = rd_word >> {off_q, 3'b000};
    mem_rdata = '0;
    for (int i = 0; i < 4; i++) begin
      if (oe_q[i]) mem_rdata[8*i +: 8] = rd_shift[8*i +: 8];
    end
  end

endmodule

// File: doc/dmem_bridge.md
# dmem_bridge

Data-side memory bridge placed directly downstream of the processor core's data memory port. It takes the core's registered requests (`mem_addr`, `mem_oe`, `mem_we`, `mem_wdata`) and decodes them to a synchronous word RAM or a small MMIO space containing a buffered 8N1 UART transmitter and a scratch register. It returns `mem_rdata`/`mem_valid` for loads and drives `mem_ready` as backpressure. Byte-lane alignment is done here: the core presents lanes and data unshifted, LSB-justified.

## Interface
- `RAM_SCALE`, 14: RAM holds 2^RAM_SCALE 32-bit words, mapped at 0x0000_0000.
- `FIFO_LOG`, 4: UART TX FIFO depth is 2^FIFO_LOG bytes.
- `BAUD_DIV`, 868: clock cycles per UART bit; must be ≥ 2.
- Clocking and reset: one clock; reset is synchronous and active-high (`clk`, `rst`).
- `clk`  in  1  clock
- `rst`  in  1  synchronous active-high reset
- `mem_addr`  in  32  byte address of the request
- `mem_oe`  in  4  LSB-justified byte lanes; nonzero = access present
- `mem_we`  in  4  LSB-justified write lanes; nonzero = store, which takes priority over `mem_oe`
- `mem_wdata`  in  32  LSB-justified store data
- `mem_rdata`  out  32  load data, LSB-justified, upper bytes zero
- `mem_valid`  out  1  one-cycle pulse: `mem_rdata` valid for the last load
- `mem_ready`  out  1  bridge can accept a request on the next cycle
- `uart_txd`  out  1  serial output, idle high

## Operation
- Request decode, for a cycle N with `|mem_oe`:
  - `|mem_we` means a store.
  - Otherwise it is a load.
  - Let off = `mem_addr[1:0]`.
- Store lane alignment:
  - Lanes are `(mem_we << off) & 4'hf`.
  - Data is `mem_wdata << 8*off`.
  - Lanes shifted past bit 3 are dropped. There is no misalignment trap.
- Load data: word read at `mem_addr[RAM_SCALE+1:2]`, then `>> 8*off`, with vacated upper bytes zero.
- Address map. The region is selected by `mem_addr[31]`. Unmapped offsets read 0 and ignore writes.
  - Addresses below 0x8000_0000 go to RAM, using index bits only (aliasing is allowed).
  - 0x8000_0000 TXDATA, write: byte lane 0 (after alignment) is pushed to the TX FIFO. Read returns 0.
  - 0x8000_0004 STATUS, read-only:
    - bit0 FIFO empty
    - bit1 FIFO full
    - bit2 sticky overflow, cleared by a STATUS read
    - bit3 serializer busy
    - bits[FIFO_LOG+8:8] FIFO count
  - 0x8000_0008 SCRATCH: 32-bit R/W with byte-lane writes. Reset value 0.
- Overflow: a push while the FIFO is full is dropped and sets the overflow bit.
- `mem_ready` = !rst && (free FIFO entries ≥ 2). The margin of 2 covers a store already on the bus.
- Serializer FSM:
  - IDLE → START when the FIFO is non-empty; the byte is popped on that transition.
  - START (txd=0) → DATA: 8 bits, LSB first.
  - DATA → STOP (txd=1) → IDLE.
  - Each state or bit lasts BAUD_DIV cycles.
- FIFO simultaneous push and pop: both take effect and the count is unchanged. A push when full with a pop in the same cycle is accepted.

## Timing
- Load in cycle N: `mem_valid`=1 in cycle N+1 only, with `mem_rdata` valid. `mem_rdata` holds until the next load's valid pulse. RAM and MMIO loads have equal latency.
- Stores commit at the clock edge ending cycle N. A load at the same address in cycle N+1 returns the new data.
- Back-to-back load in N+1 after a load in N: valid in N+2. No internal queue; one-cycle latency is fixed.
- `mem_ready` is combinational from the FIFO count and reflects the state after the current cycle's push/pop.
- The byte pushed in cycle N appears as a start bit on `uart_txd` no earlier than N+2 when the serializer is idle. One frame is 10×BAUD_DIV cycles.
- Reset values:
  - `mem_rdata`=0, `mem_valid`=0, `mem_ready`=0 (during rst), `uart_txd`=1.
  - FIFO empty, overflow=0, SCRATCH=0, FSM IDLE.
  - RAM contents are not cleared.
- Reset mid-operation: a pending valid is cancelled; a frame in progress is aborted with txd high on the next cycle; FIFO contents are discarded.

## Structure
- Shared package constants: region base 32'h8000_0000, MMIO offsets TXDATA/STATUS/SCRATCH, STATUS bit positions.
- Sub-module `uart_tx`: FIFO plus serializer FSM. Its ports are push/data/full/count/busy/txd.
- Lane/shift logic and RAM stay in the top module. The RAM uses the existing bare RAM primitive.

## Test plan
- Store SW 0x11223344 @0x100, then LB @0x101, LBU-lanes @0x103, LH @0x102:
  - LB @0x101 → rdata 0x33, valid exactly one cycle after the request.
  - LBU-lanes @0x103 → 0x11.
  - LH @0x102 → 0x1122.
- SB 0xAB @0x102 over 0x11223344, then LW @0x100 → 0x11AB3344. Store at N, load at N+1 returns the new value.
- Write 'U' (0x55) to 0x8000_0000 with BAUD_DIV=4: `uart_txd` shows 0,1,0,1,0,1,0,1,0,1, each level 4 cycles, then idle high. STATUS bit3 is high during the frame.
- Push 17 bytes with FIFO_LOG=4 and the serializer stalled mid-frame:
  - `mem_ready` drops at 15 entries.
  - The 17th push sets STATUS bit2, which clears after a STATUS read.
- Read 0x8000_0010 → 0. Write/read SCRATCH with SH 0xBEEF @0x8000_000A → 0xBEEF0000.
- Assert rst for 1 cycle mid-frame and one cycle after a load: `uart_txd`=1 and `mem_valid`=0 next cycle. STATUS reads empty, count 0.
